// File: rtl/noc_inject_ni_pkg.sv
// Shared types and field layout for the NoC injection interface.
// Flit layout: payload, type, source and destination fields.
package noc_pkg;

   typedef enum logic [1:0] {
      FT_BODY   = 2'b00,
      FT_HEAD   = 2'b01,
      FT_TAIL   = 2'b10,
      FT_SINGLE = 2'b11
   } flit_type_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SEND = 2'b01,
      ST_DROP = 2'b10
   } state_e;

   localparam int PAY_LSB  = 32;
   localparam int PAY_W    = 32;
   localparam int TYPE_LSB = 24;
   localparam int TYPE_W   = 2;
   localparam int SRC_LSB  = 16;
   localparam int SRC_W    = 8;
   localparam int DST_LSB  = 0;
   localparam int DST_W    = 16;

endpackage

// File: rtl/noc_inject_ni_if.sv
// Descriptor, payload and flit handshakes of the injection NI.
// master is the NI side; slave is the source/router side.
interface noc_inject_ni_if #(
   parameter int FLIT_W = 64
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [7:0]        cmd_dst_r;
   logic [7:0]        cmd_dst_c;
   logic [3:0]        cmd_len;
   logic              data_valid;
   logic              data_ready;
   logic [31:0]       data_word;
   logic [FLIT_W-1:0] flit_out;
   logic              valid_out;
   logic              ready_in;

   modport master (
      input  cmd_valid, cmd_dst_r, cmd_dst_c, cmd_len,
      output cmd_ready,
      input  data_valid, data_word,
      output data_ready,
      output flit_out, valid_out,
      input  ready_in
   );

   modport slave (
      output cmd_valid, cmd_dst_r, cmd_dst_c, cmd_len,
      input  cmd_ready,
      output data_valid, data_word,
      input  data_ready,
      input  flit_out, valid_out,
      output ready_in
   );
endinterface

// File: rtl/noc_inject_ni_flit_pack.sv
// Combinational flit assembly; bits 31:26 and above 63 stay zero
// so the router never sees multicast flags.
module noc_flit_pack
   import noc_pkg::*;
#(
   parameter int FLIT_W = 64
) (
   input  logic [31:0]       payload,
   input  flit_type_e        ftype,
   input  logic [3:0]        src_r,
   input  logic [3:0]        src_c,
   input  logic [7:0]        dst_r,
   input  logic [7:0]        dst_c,
   output logic [FLIT_W-1:0] flit
);

   always_comb begin
      flit = '0;
      flit[PAY_LSB +: PAY_W]   = payload;
      flit[TYPE_LSB +: TYPE_W] = ftype;
      flit[SRC_LSB +: SRC_W]   = {src_r, src_c};
      flit[DST_LSB +: DST_W]   = {dst_r, dst_c};
   end

endmodule

// File: rtl/noc_inject_ni.sv
// Packetising injection NI: one descriptor plus len payload words
// become HEAD/BODY/TAIL (or SINGLE) flits through one output register.
module noc_inject_ni
   import noc_pkg::*;
#(
   parameter int FLIT_W    = 64,
   parameter int ROWS      = 2,
   parameter int COLS      = 2,
   parameter int R         = 0,
   parameter int C         = 0,
   parameter int MAX_LEN   = 8,
   parameter int STALL_MAX = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   noc_inject_ni_if.master       bus,
   output logic                  busy_o,
   output logic [15:0]           pkt_cnt_o,
   output logic [7:0]            err_cnt_o,
   output logic                  stall_o
);

   localparam int SW = $clog2(STALL_MAX + 1);

   state_e            state_q, state_d;
   logic [7:0]        dst_r_q, dst_r_d;
   logic [7:0]        dst_c_q, dst_c_d;
   logic [3:0]        len_q, len_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic [FLIT_W-1:0] flit_q, flit_d;
   logic [15:0]       pkt_q, pkt_d;
   logic [7:0]        err_q, err_d;
   logic [SW-1:0]     scnt_q, scnt_d;
   logic              stall_q, stall_d;

   logic              dh, out_hs, last, cmd_ok;
   flit_type_e        ftype;
   logic [FLIT_W-1:0] packed_flit;

   function automatic logic len_legal(logic [3:0] l);
      return (l != 4'd0) && (int'(l) <= MAX_LEN);
   endfunction

   assign cmd_ok = len_legal(bus.cmd_len)
                && (int'(bus.cmd_dst_r) < ROWS)
                && (int'(bus.cmd_dst_c) < COLS);

   assign bus.cmd_ready = (state_q == ST_IDLE);

   always_comb begin
      bus.data_ready = 1'b0;
      unique case (state_q)
         ST_SEND: bus.data_ready = !valid_q || bus.ready_in;
         ST_DROP: bus.data_ready = len_legal(len_q);
         default: bus.data_ready = 1'b0;
      endcase
   end

   assign dh     = bus.data_valid && bus.data_ready;
   assign out_hs = valid_q && bus.ready_in;
   assign last   = (cnt_q == len_q - 4'd1);

   always_comb begin
      if (len_q == 4'd1)      ftype = FT_SINGLE;
      else if (cnt_q == 4'd0) ftype = FT_HEAD;
      else if (last)          ftype = FT_TAIL;
      else                    ftype = FT_BODY;
   end

   noc_flit_pack #(.FLIT_W(FLIT_W)) u_pack (
      .payload (bus.data_word),
      .ftype   (ftype),
      .src_r   (4'(R)),
      .src_c   (4'(C)),
      .dst_r   (dst_r_q),
      .dst_c   (dst_c_q),
      .flit    (packed_flit)
   );

   always_comb begin
      state_d = state_q;
      dst_r_d = dst_r_q;
      dst_c_d = dst_c_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      flit_d  = flit_q;
      pkt_d   = pkt_q;
      err_d   = err_q;
      scnt_d  = '0;
      stall_d = stall_q;

      if (out_hs) valid_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               dst_r_d = bus.cmd_dst_r;
               dst_c_d = bus.cmd_dst_c;
               len_d   = bus.cmd_len;
               cnt_d   = 4'd0;
               if (cmd_ok) begin
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_DROP;
                  if (err_q != 8'hFF) err_d = err_q + 8'd1;
               end
            end
         end
         ST_SEND: begin
            if (dh) begin
               cnt_d   = cnt_q + 4'd1;
               valid_d = 1'b1;
               flit_d  = packed_flit;
               if (last) state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (!len_legal(len_q)) begin
               state_d = ST_IDLE;
            end else if (dh) begin
               cnt_d = cnt_q + 4'd1;
               if (last) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // bit 25 of the type field is set only for TAIL and SINGLE
      if (out_hs && flit_q[TYPE_LSB+1] && pkt_q != 16'hFFFF)
         pkt_d = pkt_q + 16'd1;

      if (valid_q && !bus.ready_in)
         scnt_d = (scnt_q == SW'(STALL_MAX)) ? scnt_q : scnt_q + 1'b1;
      if (scnt_d == SW'(STALL_MAX)) stall_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         dst_r_q <= '0;
         dst_c_q <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         flit_q  <= '0;
         pkt_q   <= '0;
         err_q   <= '0;
         scnt_q  <= '0;
         stall_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dst_r_q <= dst_r_d;
         dst_c_q <= dst_c_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         flit_q  <= flit_d;
         pkt_q   <= pkt_d;
         err_q   <= err_d;
         scnt_q  <= scnt_d;
         stall_q <= stall_d;
      end
   end

   assign bus.flit_out  = flit_q;
   assign bus.valid_out = valid_q;
   assign busy_o        = (state_q != ST_IDLE);
   assign pkt_cnt_o     = pkt_q;
   assign err_cnt_o     = err_q;
   assign stall_o       = stall_q;

endmodule
